// File: rtl/enigma_pkg.sv
// Shared widths, beat layout and source encoding for the enigma two-to-one arbiter.
package enigma_pkg;

    localparam int unsigned PAYLOAD_W = 128;
    localparam int unsigned SID_W     = 5;
    localparam int unsigned QOS_W     = 2;
    localparam int unsigned CID_W     = SID_W + 1;

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [SID_W-1:0]     id;
        logic [QOS_W-1:0]     qos;
    } enigma_beat_t;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } enigma_src_t;

    // Merged-stream ID: source port in the MSB, original ID below it.
    function automatic logic [CID_W-1:0] make_cid(enigma_src_t src, logic [SID_W-1:0] id);
        return {src, id};
    endfunction

endpackage

// File: rtl/enigma_skid.sv
// Per-input beat buffer: BUF_DEPTH-entry FIFO with registered full/empty flags.
module enigma_skid
    import enigma_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  enigma_beat_t wr_beat,
    input  logic         rd_en,
    output enigma_beat_t rd_beat,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    enigma_beat_t     mem [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             do_wr;
    logic             do_rd;

    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_beat = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_wr && !do_rd) begin
            count_next = count + CNT_W'(1);
        end else if (do_rd && !do_wr) begin
            count_next = count - CNT_W'(1);
        end
    end

    // full is forced high in reset so the upstream port reads not-ready until released.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b1;
            empty  <= 1'b1;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
            full  <= (count_next == CNT_W'(BUF_DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_beat;
    end

endmodule

// File: rtl/enigma_arbiter.sv
// Two-to-one QoS arbiter with per-ID outstanding tracking and conflict retry on the merged port.
module enigma_arbiter
    import enigma_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PAYLOAD_W-1:0] payload_a,
    input  logic [SID_W-1:0]     id_a,
    input  logic [QOS_W-1:0]     qos_a,
    input  logic                 valid_a,
    output logic                 ready_a,
    input  logic [PAYLOAD_W-1:0] payload_b,
    input  logic [SID_W-1:0]     id_b,
    input  logic [QOS_W-1:0]     qos_b,
    input  logic                 valid_b,
    output logic                 ready_b,
    output logic [PAYLOAD_W-1:0] payload_c,
    output logic [CID_W-1:0]     id_c,
    output logic [QOS_W-1:0]     qos_c,
    output logic                 valid_c,
    input  logic                 ready_c,
    input  logic                 conflict_c,
    input  logic                 release_c,
    input  logic [CID_W-1:0]     releaseid_c,
    output logic                 err_release
);

    enigma_beat_t             in_a, in_b, head_a, head_b, sel_beat;
    logic                     full_a, empty_a, full_b, empty_b;
    logic                     elig_a, elig_b, grant_a, grant_b;
    logic                     complete, load;
    logic [CID_W-1:0]         cid_a, cid_b, sel_cid;
    logic [(1<<CID_W)-1:0]    outst_q, outst_next;
    logic                     err_next;
    enigma_src_t              rr_q, rr_next;

    assign in_a = {payload_a, id_a, qos_a};
    assign in_b = {payload_b, id_b, qos_b};

    enigma_skid #(.BUF_DEPTH(BUF_DEPTH)) u_skid_a (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (valid_a & ready_a),
        .wr_beat (in_a),
        .rd_en   (grant_a),
        .rd_beat (head_a),
        .full    (full_a),
        .empty   (empty_a)
    );

    enigma_skid #(.BUF_DEPTH(BUF_DEPTH)) u_skid_b (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (valid_b & ready_b),
        .wr_beat (in_b),
        .rd_en   (grant_b),
        .rd_beat (head_b),
        .full    (full_b),
        .empty   (empty_b)
    );

    assign ready_a  = ~full_a;
    assign ready_b  = ~full_b;
    assign cid_a    = make_cid(SRC_A, head_a.id);
    assign cid_b    = make_cid(SRC_B, head_b.id);
    // Eligibility reads the registered table, so a same-cycle release takes effect next cycle.
    assign elig_a   = ~empty_a & ~outst_q[cid_a];
    assign elig_b   = ~empty_b & ~outst_q[cid_b];
    assign complete = valid_c & ready_c & ~conflict_c;
    assign load     = ~valid_c | complete;
    assign sel_beat = grant_b ? head_b : head_a;
    assign sel_cid  = grant_b ? cid_b : cid_a;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        rr_next = rr_q;
        if (load) begin
            if (elig_a && elig_b) begin
                if (head_a.qos > head_b.qos) begin
                    grant_a = 1'b1;
                end else if (head_b.qos > head_a.qos) begin
                    grant_b = 1'b1;
                end else if (rr_q == SRC_A) begin
                    grant_a = 1'b1;
                    rr_next = SRC_B;
                end else begin
                    grant_b = 1'b1;
                    rr_next = SRC_A;
                end
            end else if (elig_a) begin
                grant_a = 1'b1;
            end else if (elig_b) begin
                grant_b = 1'b1;
            end
        end
    end

    always_comb begin
        outst_next = outst_q;
        err_next   = err_release;
        if (release_c) begin
            if (outst_q[releaseid_c]) outst_next[releaseid_c] = 1'b0;
            else                      err_next = 1'b1;
        end
        if (grant_a || grant_b) outst_next[sel_cid] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q        <= SRC_A;
            outst_q     <= '0;
            err_release <= 1'b0;
            valid_c     <= 1'b0;
            payload_c   <= '0;
            id_c        <= '0;
            qos_c       <= '0;
        end else begin
            rr_q        <= rr_next;
            outst_q     <= outst_next;
            err_release <= err_next;
            if (load) begin
                valid_c <= grant_a | grant_b;
                if (grant_a || grant_b) begin
                    payload_c <= sel_beat.payload;
                    id_c      <= sel_cid;
                    qos_c     <= sel_beat.qos;
                end
            end
        end
    end

endmodule

// File: tb/tb_enigma_arbiter.sv
// Bench for enigma_arbiter: queue-level reference model, per-cycle compare, directed literal pins.
module tb_enigma_arbiter;
    import enigma_pkg::*;

    localparam int unsigned TB_DEPTH = 2;
    localparam int PW  = PAYLOAD_W;
    localparam int NID = 1 << CID_W;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [PAYLOAD_W-1:0] payload_a, payload_b, payload_c;
    logic [SID_W-1:0]     id_a, id_b;
    logic [QOS_W-1:0]     qos_a, qos_b, qos_c;
    logic                 valid_a, valid_b, ready_a, ready_b;
    logic [CID_W-1:0]     id_c, releaseid_c;
    logic                 valid_c, ready_c, conflict_c, release_c, err_release;

    always #5 clk = ~clk;

    enigma_arbiter #(.BUF_DEPTH(TB_DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .payload_a   (payload_a),
        .id_a        (id_a),
        .qos_a       (qos_a),
        .valid_a     (valid_a),
        .ready_a     (ready_a),
        .payload_b   (payload_b),
        .id_b        (id_b),
        .qos_b       (qos_b),
        .valid_b     (valid_b),
        .ready_b     (ready_b),
        .payload_c   (payload_c),
        .id_c        (id_c),
        .qos_c       (qos_c),
        .valid_c     (valid_c),
        .ready_c     (ready_c),
        .conflict_c  (conflict_c),
        .release_c   (release_c),
        .releaseid_c (releaseid_c),
        .err_release (err_release)
    );

    typedef struct {
        logic [PAYLOAD_W-1:0] p;
        logic [SID_W-1:0]     id;
        logic [QOS_W-1:0]     q;
    } mbeat_t;

    mbeat_t               qa[$], qb[$];
    mbeat_t               mb;
    bit                   outst [NID];
    bit                   m_valid, m_err, m_ready_a, m_ready_b;
    logic [PAYLOAD_W-1:0] m_payload;
    logic [CID_W-1:0]     m_id;
    logic [QOS_W-1:0]     m_qos;
    int                   rr, win;
    bit                   done, ea, eb;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference model: queues per port, set of outstanding merged IDs, one held C beat.
    always @(posedge clk) begin
        if (rst) begin
            qa.delete();
            qb.delete();
            foreach (outst[i]) outst[i] = 1'b0;
            m_valid = 0; m_err = 0; m_ready_a = 0; m_ready_b = 0; rr = 0;
            m_payload = '0; m_id = '0; m_qos = '0;
        end else begin
            done = m_valid && ready_c && !conflict_c;
            ea = 0;
            eb = 0;
            if (qa.size() > 0) ea = !outst[{1'b0, qa[0].id}];
            if (qb.size() > 0) eb = !outst[{1'b1, qb[0].id}];
            if (release_c) begin
                if (outst[releaseid_c]) outst[releaseid_c] = 1'b0;
                else m_err = 1'b1;
            end
            if (!m_valid || done) begin
                win = -1;
                if (ea && eb) begin
                    if (qa[0].q > qb[0].q) win = 0;
                    else if (qb[0].q > qa[0].q) win = 1;
                    else begin win = rr; rr = 1 - rr; end
                end else if (ea) win = 0;
                else if (eb) win = 1;
                if (win == 0) mb = qa.pop_front();
                else if (win == 1) mb = qb.pop_front();
                m_valid = (win >= 0);
                if (win >= 0) begin
                    m_payload = mb.p;
                    m_id = {win == 1, mb.id};
                    m_qos = mb.q;
                    outst[m_id] = 1'b1;
                end
            end
            if (valid_a && m_ready_a) qa.push_back('{payload_a, id_a, qos_a});
            if (valid_b && m_ready_b) qb.push_back('{payload_b, id_b, qos_b});
            m_ready_a = qa.size() < int'(TB_DEPTH);
            m_ready_b = qb.size() < int'(TB_DEPTH);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready_a", PW'(ready_a), PW'(m_ready_a));
            chk("ready_b", PW'(ready_b), PW'(m_ready_b));
            chk("valid_c", PW'(valid_c), PW'(m_valid));
            chk("err_release", PW'(err_release), PW'(m_err));
            if (m_valid) begin
                chk("payload_c", payload_c, m_payload);
                chk("id_c", PW'(id_c), PW'(m_id));
                chk("qos_c", PW'(qos_c), PW'(m_qos));
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_release(input logic [CID_W-1:0] rid);
        release_c = 1'b1;
        releaseid_c = rid;
        step();
        release_c = 1'b0;
    endtask

    task automatic rand_drive();
        int cand[$];
        valid_a   = ($urandom_range(0, 2) != 0);
        payload_a = {$urandom(), $urandom(), $urandom(), $urandom()};
        id_a      = SID_W'($urandom_range(0, 7));
        qos_a     = QOS_W'($urandom_range(0, 3));
        valid_b   = ($urandom_range(0, 2) != 0);
        payload_b = {$urandom(), $urandom(), $urandom(), $urandom()};
        id_b      = SID_W'($urandom_range(0, 7));
        qos_b     = QOS_W'($urandom_range(0, 3));
        ready_c    = ($urandom_range(0, 3) != 0);
        conflict_c = ($urandom_range(0, 4) == 0);
        release_c   = 1'b0;
        releaseid_c = '0;
        for (int i = 0; i < NID; i++) if (outst[i]) cand.push_back(i);
        if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
            release_c   = 1'b1;
            releaseid_c = CID_W'(cand[$urandom_range(0, cand.size() - 1)]);
        end else if ($urandom_range(0, 40) == 0) begin
            release_c   = 1'b1;
            releaseid_c = CID_W'($urandom_range(0, NID - 1));
        end
    endtask

    int na, nb;
    bit acc_a, acc_b;
    bit seq[$];

    initial begin
        rst = 1; valid_a = 0; valid_b = 0; ready_c = 0; conflict_c = 0; release_c = 0;
        payload_a = '0; payload_b = '0; id_a = '0; id_b = '0; qos_a = '0; qos_b = '0;
        releaseid_c = '0;
        step();
        chk_en = 1'b1;
        chk("rst_ready_a", PW'(ready_a), PW'(0));
        chk("rst_ready_b", PW'(ready_b), PW'(0));
        chk("rst_valid_c", PW'(valid_c), PW'(0));
        chk("rst_id_c", PW'(id_c), PW'(0));
        chk("rst_payload_c", payload_c, PW'(0));
        step(2);
        rst = 0;
        step();
        chk("post_rst_ready_a", PW'(ready_a), PW'(1));

        // Single beat A id=3 qos=1
        ready_c = 1;
        valid_a = 1; id_a = 5'd3; qos_a = 2'd1; payload_a = PW'(32'hA5A5_0003);
        step();
        valid_a = 0;
        chk("t1_not_yet", PW'(valid_c), PW'(0));
        step();
        chk("t1_valid", PW'(valid_c), PW'(1));
        chk("t1_id", PW'(id_c), PW'(6'h03));
        chk("t1_qos", PW'(qos_c), PW'(1));
        chk("t1_payload", payload_c, PW'(32'hA5A5_0003));
        step();
        do_release(6'h03);
        chk("t1_release_ok", PW'(err_release), PW'(0));
        step(2);

        // QoS priority: A qos=2 beats B qos=1
        valid_a = 1; id_a = 5'd1; qos_a = 2'd2;
        valid_b = 1; id_b = 5'd2; qos_b = 2'd1;
        step();
        valid_a = 0; valid_b = 0;
        step();
        chk("t2_first", PW'(id_c), PW'(6'h01));
        step();
        chk("t2_second", PW'(id_c), PW'(6'h22));
        step();
        do_release(6'h01);
        do_release(6'h22);
        step(2);

        // Equal QoS: strict A,B alternation
        na = 0; nb = 0;
        repeat (24) begin
            valid_a = (na < 4); id_a = SID_W'(8 + na);  qos_a = 2'd1;
            valid_b = (nb < 4); id_b = SID_W'(12 + nb); qos_b = 2'd1;
            if (valid_c && ready_c && !conflict_c) seq.push_back(id_c[SID_W]);
            acc_a = valid_a && ready_a;
            acc_b = valid_b && ready_b;
            step();
            if (acc_a) na++;
            if (acc_b) nb++;
        end
        valid_a = 0; valid_b = 0;
        chk("t3_count", PW'(seq.size()), PW'(8));
        for (int i = 0; i < seq.size() && i < 8; i++) chk("t3_src", PW'(seq[i]), PW'(i % 2));
        for (int i = 0; i < 4; i++) begin
            do_release(CID_W'(8 + i));
            do_release(CID_W'(6'h2C + i));
        end
        step(2);

        // Conflict retry: held for three rejects, completes on the fourth
        conflict_c = 1;
        valid_a = 1; id_a = 5'd7; qos_a = 2'd0; payload_a = PW'(32'hC0FF_EE07);
        step();
        valid_a = 0;
        step();
        chk("t4_valid", PW'(valid_c), PW'(1));
        repeat (3) begin
            step();
            chk("t4_hold_valid", PW'(valid_c), PW'(1));
            chk("t4_hold_id", PW'(id_c), PW'(6'h07));
            chk("t4_hold_payload", payload_c, PW'(32'hC0FF_EE07));
        end
        conflict_c = 0;
        step();
        chk("t4_done", PW'(valid_c), PW'(0));
        do_release(6'h07);
        step(2);

        // Same ID twice: second waits for release, and not in the release cycle
        valid_a = 1; id_a = 5'd5; qos_a = 2'd0;
        step(2);
        valid_a = 0;
        chk("t5_first", PW'(id_c), PW'(6'h05));
        step(2);
        chk("t5_blocked", PW'(valid_c), PW'(0));
        do_release(6'h05);
        chk("t5_release_cycle", PW'(valid_c), PW'(0));
        step();
        chk("t5_second_valid", PW'(valid_c), PW'(1));
        chk("t5_second_id", PW'(id_c), PW'(6'h05));
        step();
        do_release(6'h05);
        chk("t5_no_err", PW'(err_release), PW'(0));

        // Release of an ID that is not outstanding
        do_release(6'h21);
        chk("t6_err", PW'(err_release), PW'(1));

        // Randomized traffic with a mid-burst reset
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                chk("t6_err_sticky", PW'(err_release), PW'(1));
                rst = 1;
                rand_drive();
                step();
                chk("mid_rst_valid_c", PW'(valid_c), PW'(0));
                chk("mid_rst_ready_a", PW'(ready_a), PW'(0));
                chk("mid_rst_ready_b", PW'(ready_b), PW'(0));
                chk("mid_rst_err", PW'(err_release), PW'(0));
                step();
                rst = 0;
                rand_drive();
                step();
                chk("after_rst_ready_a", PW'(ready_a), PW'(1));
                chk("after_rst_valid_c", PW'(valid_c), PW'(0));
            end
            rand_drive();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
